// File: rtl/imm_ext_pipe.sv
// Immediate extender feeding a 2-entry elastic FIFO between ID and EX.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   flush               - synchronous squash of all buffered entries
//   in_valid/in_ready   - producer handshake; in_imm, in_op, in_tag are the payload
//   out_valid/out_ready - consumer handshake; out_data, out_tag show the head entry
//   occupancy           - number of buffered entries (0..2)
module imm_ext_pipe #(
   parameter int unsigned IN_W     = 16,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned BR_SHIFT = 2,
   parameter int unsigned TAG_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic [1:0]       occupancy
);

   localparam int unsigned EXT_W = OUT_W - IN_W;

   localparam logic [1:0] OP_SIGN  = 2'd0;
   localparam logic [1:0] OP_ZERO  = 2'd1;
   localparam logic [1:0] OP_UPPER = 2'd2;
   localparam logic [1:0] OP_BR    = 2'd3;

   logic [OUT_W-1:0] sext_c;
   logic [OUT_W-1:0] ext_c;
   logic             accept_c;
   logic             pop_c;

   logic [1:0]       occ_q, occ_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [OUT_W-1:0] data_q [2];
   logic [OUT_W-1:0] data_d [2];
   logic [TAG_W-1:0] tag_q  [2];
   logic [TAG_W-1:0] tag_d  [2];

   // Extension datapath; the upper-mode concatenation is exactly OUT_W wide.
   always_comb begin
      sext_c = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
      ext_c  = '0;
      case (in_op)
         OP_SIGN:  ext_c = sext_c;
         OP_ZERO:  ext_c = {{EXT_W{1'b0}}, in_imm};
         OP_UPPER: ext_c = {in_imm, {EXT_W{1'b0}}};
         OP_BR:    ext_c = sext_c << BR_SHIFT;
         default:  ext_c = sext_c;
      endcase
   end

   // Handshake signals depend only on registered state (and reset gating).
   assign in_ready  = (occ_q != 2'd2) && !reset;
   assign out_valid = (occ_q != 2'd0) && !reset;
   assign out_data  = reset ? '0 : data_q[rd_ptr_q];
   assign out_tag   = reset ? '0 : tag_q[rd_ptr_q];
   assign occupancy = occ_q;

   // Flush drops any offered entry, so it also blocks the write.
   assign accept_c = in_valid && in_ready && !flush;
   assign pop_c    = out_valid && out_ready;

   // Next-state for pointers, occupancy and storage.
   always_comb begin
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
      tag_d    = tag_q;

      if (accept_c) begin
         data_d[wr_ptr_q] = ext_c;
         tag_d[wr_ptr_q]  = in_tag;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop_c) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({accept_c, pop_c})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      if (flush) begin
         occ_d    = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end
   end

   // State register; reset clears the stored entries as well.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q     <= 2'd0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         tag_q[0]  <= '0;
         tag_q[1]  <= '0;
      end else begin
         occ_q     <= occ_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         data_q[0] <= data_d[0];
         data_q[1] <= data_d[1];
         tag_q[0]  <= tag_d[0];
         tag_q[1]  <= tag_d[1];
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: directed vectors with hand-computed results.
module tb_imm_ext_pipe;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  t;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [15:0] in_imm;
   logic [1:0]  in_op;
   logic [4:0]  in_tag;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic [1:0]  occupancy;

   logic        s_in_valid, s_in_ready, s_out_valid;
   logic [7:0]  s_in_imm;
   logic [1:0]  s_in_op;
   logic [4:0]  s_in_tag;
   logic [15:0] s_out_data;
   logic [4:0]  s_out_tag;
   logic [1:0]  s_occupancy;

   exp_t exp_cur;
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imm_ext_pipe u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .occupancy(occupancy)
   );

   imm_ext_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(2), .TAG_W(5)) u_small (
      .clk(clk), .reset(reset), .flush(1'b0),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm),
      .in_op(s_in_op), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
      .out_tag(s_out_tag), .occupancy(s_occupancy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] imm, input logic [1:0] op,
                        input logic [4:0] tag, input logic [31:0] exp_d);
      in_valid  = 1'b1;
      in_imm    = imm;
      in_op     = op;
      in_tag    = tag;
      exp_cur.d = exp_d;
      exp_cur.t = tag;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || occupancy != 2'd0) && n < 20) begin
         step();
         n++;
      end
      @(negedge clk);
      chk(name, {30'd0, occupancy}, 32'd0);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d results still outstanding", name, sb_q.size());
      end
   endtask

   // Monitor: compare each popped head against the scoreboard, then record accepts.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL pop: unexpected output %h tag %0d", out_data, out_tag);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               if (out_data !== e.d || out_tag !== e.t) begin
                  errors++;
                  $display("FAIL pop: got %h/%0d expected %h/%0d at %0t",
                           out_data, out_tag, e.d, e.t, $time);
               end
            end
         end
         if (flush) sb_q.delete();
         else if (in_valid && in_ready) sb_q.push_back(exp_cur);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_imm = '0; in_op = '0; in_tag = '0; exp_cur = '0;
      s_in_valid = 1'b0; s_in_imm = '0; s_in_op = '0; s_in_tag = '0;
      step(); step();
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_occ", {30'd0, occupancy}, 32'd0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single sign-extended item with one-cycle latency.
      out_ready = 1'b1;
      step();
      drive(16'h8001, 2'd0, 5'd3, 32'hFFFF8001);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_out_data", out_data, 32'hFFFF8001);
      chk("t1_out_tag", {27'd0, out_tag}, 32'd3);
      step();
      @(negedge clk);
      chk("t1_occ_back", {30'd0, occupancy}, 32'd0);

      // Remaining modes back to back.
      step();
      drive(16'h8001, 2'd1, 5'd4, 32'h00008001); step();
      drive(16'h8001, 2'd2, 5'd5, 32'h80010000); step();
      drive(16'h8001, 2'd3, 5'd6, 32'hFFFE0004); step();
      in_valid = 1'b0;
      wait_drain("t2_drain");

      // Backpressure: A, B fill the buffer, C is held until a slot opens.
      out_ready = 1'b0;
      step();
      drive(16'h0001, 2'd0, 5'd1, 32'h00000001); step();
      drive(16'h7FFF, 2'd1, 5'd2, 32'h00007FFF); step();
      drive(16'h1234, 2'd2, 5'd4, 32'h12340000); step();
      @(negedge clk);
      chk("t3_occ_full", {30'd0, occupancy}, 32'd2);
      chk("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_ready_blind_to_pop", {31'd0, in_ready}, 32'd0);
      step();
      @(negedge clk);
      chk("t3_in_ready_after_pop", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      wait_drain("t3_drain");

      // Steady state at occupancy 1: accept and pop every cycle.
      out_ready = 1'b0;
      step();
      drive(16'hFFFF, 2'd0, 5'd7, 32'hFFFFFFFF);
      step();
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         drive(16'(16'h0111 * i), 2'd3, 5'(i), 32'(32'h0444 * i));
         @(negedge clk);
         chk("t4_occ_steady", {30'd0, occupancy}, 32'd1);
         step();
      end
      in_valid = 1'b0;
      wait_drain("t4_drain");

      // Flush at occupancy 2 with an offer pending.
      out_ready = 1'b0;
      step();
      drive(16'h0010, 2'd1, 5'd8, 32'h00000010); step();
      drive(16'h0020, 2'd1, 5'd9, 32'h00000020); step();
      drive(16'h0030, 2'd1, 5'd10, 32'h00000030);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_occ_flush2", {30'd0, occupancy}, 32'd0);
      chk("t5_out_valid_flush2", {31'd0, out_valid}, 32'd0);
      chk("t5_in_ready_flush2", {31'd0, in_ready}, 32'd1);

      // Flush at occupancy 1 while an offer is accepted by the handshake.
      step();
      drive(16'h0040, 2'd1, 5'd11, 32'h00000040); step();
      drive(16'h0050, 2'd1, 5'd12, 32'h00000050);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_occ_flush1", {30'd0, occupancy}, 32'd0);
      chk("t5_out_valid_flush1", {31'd0, out_valid}, 32'd0);

      // Reset while full.
      step();
      drive(16'h0060, 2'd1, 5'd13, 32'h00000060); step();
      drive(16'h0070, 2'd1, 5'd14, 32'h00000070); step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t6_occ_pre_reset", {30'd0, occupancy}, 32'd2);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_out_valid_rst", {31'd0, out_valid}, 32'd0);
      chk("t6_out_data_rst", out_data, 32'd0);
      chk("t6_in_ready_rst", {31'd0, in_ready}, 32'd0);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("t6_occ_after", {30'd0, occupancy}, 32'd0);
      chk("t6_out_valid_after", {31'd0, out_valid}, 32'd0);

      // Narrow instance: branch mode and truncating shift, then upper mode.
      step();
      s_in_valid = 1'b1; s_in_imm = 8'hF0; s_in_op = 2'd3; s_in_tag = 5'd9;
      step();
      s_in_imm = 8'hAB; s_in_op = 2'd2; s_in_tag = 5'd17;
      @(negedge clk);
      chk("t7_small_valid", {31'd0, s_out_valid}, 32'd1);
      chk("t7_small_br", {16'd0, s_out_data}, 32'h0000FFC0);
      chk("t7_small_tag", {27'd0, s_out_tag}, 32'd9);
      step();
      s_in_valid = 1'b0;
      @(negedge clk);
      chk("t7_small_upper", {16'd0, s_out_data}, 32'h0000AB00);
      chk("t7_small_tag2", {27'd0, s_out_tag}, 32'd17);
      step();
      @(negedge clk);
      chk("t7_small_empty", {30'd0, s_occupancy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
